// File: rtl/instr_resp_queue.sv
// Instruction response queue between the instruction buffer and the wavepool.
// Buffers tagged instruction dwords and issues credit-based fetch stalls.
module instr_resp_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_rd_en,
   input  logic             fetchwave_ack,
   input  logic [31:0]      wave_instr,
   input  logic [38:0]      wave_tag,
   input  logic             flush,
   input  logic             resp_ready,
   output logic             resp_valid,
   output logic [31:0]      resp_instr,
   output logic [38:0]      resp_tag,
   output logic             fetch_stall,
   output logic [CNT_W-1:0] occupancy,
   output logic             overflow_err,
   output logic             protocol_err
);

   typedef struct packed {
      logic [38:0] tag;
      logic [31:0] instr;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             req_q;
   logic             drop_q;

   logic             full;
   logic             wr;
   logic             pop;
   logic             wr_ok;
   logic             ovf;
   logic [CNT_W:0]   credit;

   assign full   = (count == CNT_W'(DEPTH));
   assign wr     = fetchwave_ack & ~flush & ~drop_q;
   assign pop    = resp_valid & resp_ready & ~flush;
   assign wr_ok  = wr & (~full | pop);
   assign ovf    = wr & full & ~pop;

   // Pessimistic credit: a same-cycle pop is not counted as a free slot.
   assign credit      = {1'b0, count} + (CNT_W+1)'(fetchwave_ack);
   assign fetch_stall = (credit >= (CNT_W+1)'(DEPTH));

   assign resp_valid = (count != '0);
   assign resp_instr = mem[rd_ptr].instr;
   assign resp_tag   = mem[rd_ptr].tag;
   assign occupancy  = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[wr_ptr] <= '{tag: wave_tag, instr: wave_instr};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(wr_ok) - CNT_W'(pop);
      end
   end

   // drop_q swallows the ack of a request issued during the flush cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q        <= 1'b0;
         drop_q       <= 1'b0;
         overflow_err <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         req_q  <= fetch_rd_en;
         drop_q <= flush;
         if (ovf) overflow_err <= 1'b1;
         if (fetchwave_ack & ~req_q) protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_resp_queue.sv
// Directed self-checking bench for instr_resp_queue.
// Inputs change 1ns after each rising edge; outputs are sampled mid-cycle.
module tb_instr_resp_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_rd_en;
   logic        fetchwave_ack;
   logic [31:0] wave_instr;
   logic [38:0] wave_tag;
   logic        flush;
   logic        resp_ready;
   logic        resp_valid;
   logic [31:0] resp_instr;
   logic [38:0] resp_tag;
   logic        fetch_stall;
   logic [3:0]  occupancy;
   logic        overflow_err;
   logic        protocol_err;

   int vectors = 0;
   int miscompares = 0;

   instr_resp_queue #(.DEPTH(8), .PTR_W(3), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_rd_en  (fetch_rd_en),
      .fetchwave_ack(fetchwave_ack),
      .wave_instr   (wave_instr),
      .wave_tag     (wave_tag),
      .flush        (flush),
      .resp_ready   (resp_ready),
      .resp_valid   (resp_valid),
      .resp_instr   (resp_instr),
      .resp_tag     (resp_tag),
      .fetch_stall  (fetch_stall),
      .occupancy    (occupancy),
      .overflow_err (overflow_err),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      fetch_rd_en   = 1'b0;
      fetchwave_ack = 1'b0;
      wave_instr    = '0;
      wave_tag      = '0;
      flush         = 1'b0;
      resp_ready    = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      idle_inputs();
      repeat (2) tick();
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b want 0", resp_valid);
      end
      rst = 1'b1;
      repeat (2) tick();
      vectors++;
      if (occupancy !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_occ: got %0d want 0", occupancy);
      end
      vectors++;
      if (fetch_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_stall: got %b want 0", fetch_stall);
      end
      vectors++;
      if (resp_instr !== 32'h0 || resp_tag !== 39'h0) begin
         miscompares++;
         $display("FAIL reset_head: got %h/%h want 0/0", resp_instr, resp_tag);
      end
      vectors++;
      if (overflow_err !== 1'b0 || protocol_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err: got %b%b want 00", overflow_err, protocol_err);
      end
   endtask

   task automatic test_single_fetch;
      fetch_rd_en = 1'b1;
      tick();
      fetch_rd_en   = 1'b0;
      fetchwave_ack = 1'b1;
      wave_instr    = 32'hBF810000;
      wave_tag      = 39'h1234;
      #1;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_no_bypass: got %b want 0", resp_valid);
      end
      tick();
      fetchwave_ack = 1'b0;
      wave_instr    = '0;
      wave_tag      = '0;
      vectors++;
      if (resp_valid !== 1'b1 || resp_instr !== 32'hBF810000) begin
         miscompares++;
         $display("FAIL single_head: got %b/%h want 1/bf810000", resp_valid, resp_instr);
      end
      vectors++;
      if (resp_tag !== 39'h1234 || occupancy !== 4'd1) begin
         miscompares++;
         $display("FAIL single_tag_occ: got %h/%0d want 1234/1", resp_tag, occupancy);
      end
      vectors++;
      if (protocol_err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_proto: got %b want 0", protocol_err);
      end
      tick();
      vectors++;
      if (resp_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL single_hold: got %b want 1", resp_valid);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0 || occupancy !== 4'd0) begin
         miscompares++;
         $display("FAIL single_pop: got %b/%0d want 0/0", resp_valid, occupancy);
      end
   endtask

   task automatic test_fill;
      int   occ_m = 0;
      int   acked = 0;
      logic pend  = 1'b0;
      logic exp_stall;
      for (int c = 0; c < 12; c++) begin
         fetchwave_ack = pend;
         wave_instr    = acked;
         #1;
         exp_stall = (occ_m + int'(pend)) >= 8;
         vectors++;
         if (fetch_stall !== exp_stall) begin
            miscompares++;
            $display("FAIL fill_stall c%0d: got %b want %b", c, fetch_stall, exp_stall);
         end
         fetch_rd_en = ~exp_stall;
         if (pend) begin
            acked++;
            occ_m++;
         end
         pend = fetch_rd_en;
         tick();
      end
      idle_inputs();
      #1;
      vectors++;
      if (occupancy !== 4'd8 || overflow_err !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: got %0d/%b want 8/0", occupancy, overflow_err);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (resp_valid !== 1'b1 || resp_instr !== 32'(i)) begin
            miscompares++;
            $display("FAIL fill_pop%0d: got %b/%0d want 1/%0d", i, resp_valid, resp_instr, i);
         end
         tick();
      end
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_empty: got %b want 0", resp_valid);
      end
   endtask

   task automatic test_back_to_back;
      resp_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         fetch_rd_en   = (c < 20);
         fetchwave_ack = (c >= 1 && c <= 20);
         wave_instr    = 32'(100 + c - 1);
         #1;
         if (c >= 2) begin
            vectors++;
            if (resp_valid !== 1'b1 || resp_instr !== 32'(100 + c - 2)) begin
               miscompares++;
               $display("FAIL wrap_head c%0d: got %b/%0d want 1/%0d", c, resp_valid, resp_instr, 100 + c - 2);
            end
            vectors++;
            if (occupancy !== 4'd1) begin
               miscompares++;
               $display("FAIL wrap_occ c%0d: got %0d want 1", c, occupancy);
            end
         end
         tick();
      end
      idle_inputs();
      #1;
      vectors++;
      if (resp_valid !== 1'b0 || occupancy !== 4'd0) begin
         miscompares++;
         $display("FAIL wrap_drain: got %b/%0d want 0/0", resp_valid, occupancy);
      end
      for (int c = 0; c < 9; c++) begin
         fetch_rd_en   = (c < 8);
         fetchwave_ack = (c >= 1);
         wave_instr    = 32'(200 + c - 1);
         tick();
      end
      fetch_rd_en   = 1'b1;
      fetchwave_ack = 1'b0;
      #1;
      vectors++;
      if (occupancy !== 4'd8 || fetch_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL conc_full: got %0d/%b want 8/1", occupancy, fetch_stall);
      end
      tick();
      fetch_rd_en   = 1'b0;
      fetchwave_ack = 1'b1;
      wave_instr    = 32'd208;
      resp_ready    = 1'b1;
      #1;
      vectors++;
      if (resp_instr !== 32'd200) begin
         miscompares++;
         $display("FAIL conc_head: got %0d want 200", resp_instr);
      end
      tick();
      fetchwave_ack = 1'b0;
      resp_ready    = 1'b0;
      #1;
      vectors++;
      if (occupancy !== 4'd8 || overflow_err !== 1'b0) begin
         miscompares++;
         $display("FAIL conc_occ: got %0d/%b want 8/0", occupancy, overflow_err);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (resp_instr !== 32'(201 + i)) begin
            miscompares++;
            $display("FAIL conc_pop%0d: got %0d want %0d", i, resp_instr, 201 + i);
         end
         tick();
      end
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0 || protocol_err !== 1'b0) begin
         miscompares++;
         $display("FAIL conc_end: got %b/%b want 0/0", resp_valid, protocol_err);
      end
   endtask

   task automatic test_flush;
      for (int c = 0; c < 4; c++) begin
         fetch_rd_en   = (c < 3);
         fetchwave_ack = (c >= 1);
         wave_instr    = 32'(300 + c - 1);
         tick();
      end
      fetchwave_ack = 1'b0;
      #1;
      vectors++;
      if (occupancy !== 4'd3) begin
         miscompares++;
         $display("FAIL flush_pre: got %0d want 3", occupancy);
      end
      flush       = 1'b1;
      fetch_rd_en = 1'b1;
      tick();
      flush         = 1'b0;
      fetch_rd_en   = 1'b0;
      fetchwave_ack = 1'b1;
      wave_instr    = 32'hDEAD;
      #1;
      vectors++;
      if (occupancy !== 4'd0 || resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_clear: got %0d/%b want 0/0", occupancy, resp_valid);
      end
      tick();
      fetchwave_ack = 1'b0;
      #1;
      vectors++;
      if (occupancy !== 4'd0 || resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_drop: got %0d/%b want 0/0", occupancy, resp_valid);
      end
      vectors++;
      if (protocol_err !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_proto: got %b want 0", protocol_err);
      end
   endtask

   task automatic test_errors;
      tick();
      fetchwave_ack = 1'b1;
      wave_instr    = 32'h55;
      tick();
      fetchwave_ack = 1'b0;
      #1;
      vectors++;
      if (protocol_err !== 1'b1 || occupancy !== 4'd1) begin
         miscompares++;
         $display("FAIL proto_set: got %b/%0d want 1/1", protocol_err, occupancy);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      vectors++;
      if (protocol_err !== 1'b1 || occupancy !== 4'd0) begin
         miscompares++;
         $display("FAIL proto_sticky: got %b/%0d want 1/0", protocol_err, occupancy);
      end
      for (int c = 0; c < 10; c++) begin
         fetch_rd_en   = (c < 9);
         fetchwave_ack = (c >= 1);
         wave_instr    = (c == 9) ? 32'hBAD : 32'(400 + c - 1);
         tick();
      end
      idle_inputs();
      #1;
      vectors++;
      if (overflow_err !== 1'b1 || occupancy !== 4'd8) begin
         miscompares++;
         $display("FAIL ovf_set: got %b/%0d want 1/8", overflow_err, occupancy);
      end
      vectors++;
      if (resp_instr !== 32'd400) begin
         miscompares++;
         $display("FAIL ovf_head: got %0d want 400", resp_instr);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vectors++;
      if (overflow_err !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: got %b want 1", overflow_err);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (overflow_err !== 1'b0 || protocol_err !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async: got %b%b want 00", overflow_err, protocol_err);
      end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_fill();
      test_back_to_back();
      test_flush();
      test_errors();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
